// File: rtl/syn_weight_bank_if.sv
// Bus bundle for syn_weight_bank: bulk-load port, single-weight operation
// port and read-return strobe. master = requester, slave = weight bank.
interface syn_weight_bank_if #(
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8,
    parameter int ADDR_WIDTH = 5
);
    localparam int COL_SEL_W  = $clog2(NUM_COL);
    localparam int DATA_WIDTH = NUM_COL * COL_WIDTH;

    logic                            load_en;
    logic                            load_valid;
    logic [DATA_WIDTH-1:0]           load_data;
    logic                            load_done;
    logic                            op_valid;
    logic                            op_ready;
    logic [1:0]                      op_code;
    logic [ADDR_WIDTH+COL_SEL_W-1:0] op_addr;
    logic [COL_WIDTH-1:0]            op_data;
    logic                            rd_valid;
    logic [COL_WIDTH-1:0]            rd_data;

    modport master (
        output load_en, load_valid, load_data, op_valid, op_code, op_addr, op_data,
        input  load_done, op_ready, rd_valid, rd_data
    );

    modport slave (
        input  load_en, load_valid, load_data, op_valid, op_code, op_addr, op_data,
        output load_done, op_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/syn_weight_bank.sv
// Synaptic weight bank: word-wide bulk load, byte read/write and STDP
// read-modify-write. Define SYN_STDP_SAT_EN to clamp STDP results instead of wrapping.
module syn_weight_bank #(
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              kill,
    output logic              busy,
    output logic [1:0]        dbg_state,
    syn_weight_bank_if.slave  bus
);
    localparam int COL_SEL_W  = $clog2(NUM_COL);
    localparam int DATA_WIDTH = NUM_COL * COL_WIDTH;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;

    // Handshake: an operation is accepted on a rising edge where op_valid and
    // op_ready are both high; load beats are taken on every load_valid in LOAD.
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_UPD_RD, S_UPD_WR} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [COL_WIDTH-1:0]  rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  load_done_q, load_done_d;
    logic [ADDR_WIDTH-1:0] upd_word_q, upd_word_d;
    logic [COL_SEL_W-1:0]  upd_col_q, upd_col_d;
    logic [COL_WIDTH-1:0]  upd_delta_q, upd_delta_d;
    logic [COL_WIDTH-1:0]  upd_wgt_q, upd_wgt_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [NUM_COL-1:0]    mem_wmask;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic [ADDR_WIDTH-1:0] op_word;
    logic [COL_SEL_W-1:0]  op_col;
    logic [DATA_WIDTH-1:0] op_rd_word;
    logic [DATA_WIDTH-1:0] upd_rd_word;
    logic [COL_WIDTH-1:0]  op_wgt;
    logic [COL_WIDTH-1:0]  upd_old_wgt;

    function automatic logic [COL_WIDTH-1:0] stdp_apply(input logic [COL_WIDTH-1:0] w,
                                                        input logic [COL_WIDTH-1:0] d);
        logic [COL_WIDTH+1:0] sum;
        sum = {2'b00, w} + {{2{d[COL_WIDTH-1]}}, d};
`ifdef SYN_STDP_SAT_EN
        // Bit COL_WIDTH+1 flags a negative result, bit COL_WIDTH an overflow.
        if (sum[COL_WIDTH+1])  return '0;
        else if (sum[COL_WIDTH]) return '1;
        else                   return sum[COL_WIDTH-1:0];
`else
        return sum[COL_WIDTH-1:0];
`endif
    endfunction

    always_comb begin
        op_word     = bus.op_addr[ADDR_WIDTH+COL_SEL_W-1:COL_SEL_W];
        op_col      = bus.op_addr[COL_SEL_W-1:0];
        op_rd_word  = mem[op_word];
        upd_rd_word = mem[upd_word_q];
        op_wgt      = op_rd_word[op_col*COL_WIDTH +: COL_WIDTH];
        upd_old_wgt = upd_rd_word[upd_col_q*COL_WIDTH +: COL_WIDTH];
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        load_done_d  = 1'b0;
        upd_word_d   = upd_word_q;
        upd_col_d    = upd_col_q;
        upd_delta_d  = upd_delta_q;
        upd_wgt_d    = upd_wgt_q;
        mem_we       = 1'b0;
        mem_waddr    = op_word;
        mem_wmask    = '0;
        mem_wdata    = '0;
        bus.op_ready = (state_q == S_IDLE) && !bus.load_en;

        if (kill) begin
            state_d = S_IDLE;
            ptr_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.load_en) begin
                        state_d = S_LOAD;
                    end else if (bus.op_valid) begin
                        case (bus.op_code)
                            2'b00: begin
                                rd_valid_d = 1'b1;
                                rd_data_d  = op_wgt;
                            end
                            2'b01: begin
                                mem_we            = 1'b1;
                                mem_waddr         = op_word;
                                mem_wmask[op_col] = 1'b1;
                                mem_wdata         = {NUM_COL{bus.op_data}};
                            end
                            2'b10: begin
                                upd_word_d  = op_word;
                                upd_col_d   = op_col;
                                upd_delta_d = bus.op_data;
                                state_d     = S_UPD_RD;
                            end
                            default: ;
                        endcase
                    end
                end
                S_LOAD: begin
                    if (bus.load_valid) begin
                        mem_we    = 1'b1;
                        mem_waddr = ptr_q;
                        mem_wmask = '1;
                        mem_wdata = bus.load_data;
                        ptr_d     = ptr_q + 1'b1;
                        if (ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                            load_done_d = 1'b1;
                            state_d     = S_IDLE;
                        end
                    end
                end
                S_UPD_RD: begin
                    upd_wgt_d = upd_old_wgt;
                    state_d   = S_UPD_WR;
                end
                S_UPD_WR: begin
                    mem_we               = 1'b1;
                    mem_waddr            = upd_word_q;
                    mem_wmask[upd_col_q] = 1'b1;
                    mem_wdata            = {NUM_COL{stdp_apply(upd_wgt_q, upd_delta_q)}};
                    state_d              = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            load_done_q <= 1'b0;
            upd_word_q  <= '0;
            upd_col_q   <= '0;
            upd_delta_q <= '0;
            upd_wgt_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            load_done_q <= load_done_d;
            upd_word_q  <= upd_word_d;
            upd_col_q   <= upd_col_d;
            upd_delta_q <= upd_delta_d;
            upd_wgt_q   <= upd_wgt_d;
        end
    end

    // Contents survive reset; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (mem_we && rst) begin
            for (int c = 0; c < NUM_COL; c++) begin
                if (mem_wmask[c]) begin
                    mem[mem_waddr][c*COL_WIDTH +: COL_WIDTH] <= mem_wdata[c*COL_WIDTH +: COL_WIDTH];
                end
            end
        end
    end

    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.load_done = load_done_q;
    assign busy          = (state_q != S_IDLE);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_syn_weight_bank.sv
// Self-checking bench for syn_weight_bank: scoreboard of expected read data
// against a byte-level model of the weight table.
module tb_syn_weight_bank;
    localparam int NUM_COL    = 4;
    localparam int COL_WIDTH  = 8;
    localparam int ADDR_WIDTH = 5;
    localparam int DEPTH      = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       kill = 1'b0;
    logic       busy;
    logic [1:0] dbg_state;

    syn_weight_bank_if #(.NUM_COL(NUM_COL), .COL_WIDTH(COL_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    syn_weight_bank #(.NUM_COL(NUM_COL), .COL_WIDTH(COL_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .kill      (kill),
        .busy      (busy),
        .dbg_state (dbg_state),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int ld_cnt   = 0;
    logic [COL_WIDTH-1:0] exp_q[$];
    logic [31:0] model [DEPTH];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] get_byte(input int addr);
        logic [31:0] w;
        w = model[addr / 4];
        return w[(addr % 4)*8 +: 8];
    endfunction

    function automatic void set_byte(input int addr, input logic [7:0] v);
        logic [31:0] w;
        w = model[addr / 4];
        w[(addr % 4)*8 +: 8] = v;
        model[addr / 4] = w;
    endfunction

    function automatic logic [7:0] stdp_model(input logic [7:0] w, input logic [7:0] d);
        int s;
        s = int'(w) + int'(d);
        if (d[7]) s = s - 256;
`ifdef SYN_STDP_SAT_EN
        if (s < 0)   s = 0;
        if (s > 255) s = 255;
`endif
        return s[7:0];
    endfunction

    // Scoreboard: pop one expected weight per read strobe.
    always @(negedge clk) begin
        if (bus.load_done) ld_cnt++;
        if (bus.rd_valid) begin
            if (exp_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
            else                   check("rd_data", bus.rd_data, exp_q.pop_front());
        end
    end

    task automatic issue_op(input logic [1:0] code, input int addr, input logic [7:0] data);
        int n;
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        bus.op_addr  = 7'(addr);
        bus.op_data  = data;
        #1;
        n = 0;
        while (!bus.op_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) check("op_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        case (code)
            2'b00: exp_q.push_back(get_byte(addr));
            2'b01: set_byte(addr, data);
            2'b10: set_byte(addr, stdp_model(get_byte(addr), data));
            default: ;
        endcase
        #1;
        bus.op_valid = 1'b0;
    endtask

    task automatic load_table(input int n_beats, input logic [31:0] base, input logic [31:0] step);
        @(posedge clk); #1;
        bus.load_en = 1'b1;
        @(posedge clk); #1;
        bus.load_en = 1'b0;
        for (int i = 0; i < n_beats; i++) begin
            repeat ($urandom_range(0, 1)) begin
                bus.load_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.load_valid = 1'b1;
            bus.load_data  = base + step * i;
            @(posedge clk);
            model[i] = base + step * i;
            #1;
        end
        bus.load_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        int ld0;
        int cnt;
        logic [7:0] saved;

        bus.load_en    = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.op_valid   = 1'b0;
        bus.op_code    = 2'b00;
        bus.op_addr    = '0;
        bus.op_data    = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_load_done", bus.load_done, 0);
        rst = 1'b1;

        // Full table load
        ld0 = ld_cnt;
        load_table(32, 32'h03020100, 32'h04040404);
        @(negedge clk);
        check("load_done_pulse", bus.load_done, 1);
        check("load_busy_after", busy, 0);
        @(negedge clk);
        check("load_done_low", bus.load_done, 0);
        #1;
        check("load_done_count", ld_cnt - ld0, 1);

        // Single read, then hold
        issue_op(2'b00, 5, 8'h00);
        @(negedge clk);
        @(negedge clk);
        check("rd_valid_low", bus.rd_valid, 0);
        check("rd_data_hold", bus.rd_data, 32'h05);

        // Byte write and back-to-back reads of the whole word
        issue_op(2'b01, 6, 8'hAA);
        for (int a = 4; a < 8; a++) issue_op(2'b00, a, 8'h00);

        // STDP update: op_ready low for two cycles, then immediate read
        issue_op(2'b10, 5, 8'h10);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.op_ready) break;
            cnt++;
        end
        check("stdp_ready_low", cnt, 2);
        issue_op(2'b00, 5, 8'h00);

        // Saturation / wrap corners
        issue_op(2'b01, 9, 8'hF0);
        issue_op(2'b10, 9, 8'h20);
        issue_op(2'b00, 9, 8'h00);
        issue_op(2'b01, 10, 8'h05);
        issue_op(2'b10, 10, 8'hF0);
        issue_op(2'b00, 10, 8'h00);
        issue_op(2'b11, 10, 8'h77);
        issue_op(2'b00, 10, 8'h00);

        // Kill after 10 beats, with a same-cycle beat that must be dropped
        repeat (2) @(negedge clk);
        ld0 = ld_cnt;
        load_table(10, 32'h11111111, 32'h00000001);
        kill           = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = 32'hDEADBEEF;
        @(posedge clk); #1;
        kill           = 1'b0;
        bus.load_valid = 1'b0;
        @(negedge clk);
        check("kill_busy", busy, 0);
        repeat (3) @(negedge clk);
        #1;
        check("kill_no_load_done", ld_cnt - ld0, 0);
        issue_op(2'b00, 40, 8'h00);
        issue_op(2'b00, 2, 8'h00);

        // Reload must restart from word 0
        load_table(32, 32'h03020100, 32'h04040404);
        @(negedge clk);
        check("reload_done_pulse", bus.load_done, 1);
        issue_op(2'b00, 0, 8'h00);
        issue_op(2'b00, 41, 8'h00);
        issue_op(2'b00, 127, 8'h00);

        // Reset asserted in UPD_WR: update must not land
        saved = get_byte(3);
        issue_op(2'b10, 3, 8'h01);
        set_byte(3, saved);
        @(posedge clk); #1;
        check("upd_wr_state", dbg_state, 3);
        rst = 1'b0;
        #1;
        check("rst2_busy", busy, 0);
        check("rst2_state", dbg_state, 0);
        check("rst2_rd_valid", bus.rd_valid, 0);
        check("rst2_rd_data", bus.rd_data, 0);
        check("rst2_load_done", bus.load_done, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        issue_op(2'b00, 3, 8'h00);

        // Random mix of writes and reads
        for (int i = 0; i < 12; i++) begin
            issue_op(($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00,
                     int'($urandom_range(0, 127)), 8'($urandom_range(0, 255)));
        end

        repeat (4) @(negedge clk);
        #1;
        check("exp_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/syn_weight_bank.md
SYN_WEIGHT_BANK -- requirements
Module: syn_weight_bank

Interface
REQ-001 SHALL have parameter NUM_COL, default 4, giving weight bytes (columns) per memory word.
REQ-002 SHALL have parameter COL_WIDTH, default 8, giving bits per weight.
REQ-003 SHALL have parameter ADDR_WIDTH, default 5, giving word-address bits (depth 2**ADDR_WIDTH).
REQ-004 SHALL derive localparams COL_SEL_W = clog2(NUM_COL) and DATA_WIDTH = NUM_COL*COL_WIDTH.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port kill, input, 1, synchronous abort/flush.
REQ-008 SHALL have port load_en, input, 1, start of a bulk table load.
REQ-009 SHALL have port load_valid, input, 1, one load beat present.
REQ-010 SHALL have port load_data, input, DATA_WIDTH, one full word per beat.
REQ-011 SHALL have port load_done, output, 1, one-cycle pulse after the last load beat.
REQ-012 SHALL have port op_valid, input, 1, operation request.
REQ-013 SHALL have port op_ready, output, 1, operation accept.
REQ-014 SHALL have port op_code, input, 2, 00 read, 01 byte write, 10 STDP update, 11 reserved.
REQ-015 SHALL have port op_addr, input, ADDR_WIDTH+COL_SEL_W, synapse index: upper bits word, lower COL_SEL_W bits column.
REQ-016 SHALL have port op_data, input, COL_WIDTH, write value (01) or two's-complement delta (10).
REQ-017 SHALL have port rd_valid, output, 1, read-data strobe.
REQ-018 SHALL have port rd_data, output, COL_WIDTH, read weight.
REQ-019 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD, UPD_RD, UPD_WR; op_ready = 1 only in IDLE with load_en low.
REQ-021 SHALL leave IDLE for LOAD on load_en; load_en takes priority over op_valid in the same cycle.
REQ-022 SHALL, in LOAD, write load_data to word ptr on each load_valid and increment ptr; the beat at ptr = 2**ADDR_WIDTH-1 wraps ptr to 0, pulses load_done next cycle, and returns to IDLE.
REQ-023 SHALL, for an accepted read, assert rd_valid for exactly one cycle on the following cycle, with rd_data = addressed column; state stays IDLE, so back-to-back reads give one result per cycle.
REQ-024 SHALL hold rd_data between reads; rd_valid is low otherwise.
REQ-025 SHALL, for an accepted byte write, update only the addressed column on the acceptance edge; other columns of the word are unchanged.
REQ-026 SHALL, for an accepted STDP update, latch addr/delta, go UPD_RD (read word), then UPD_WR (write weight+delta to addressed column), then IDLE; op_ready is low for exactly 2 cycles.
REQ-027 SHALL have an accepted read issued immediately after an update to the same address return the updated value.
REQ-028 SHALL accept op_code 11 and take no action.
REQ-029 SHALL, on kill, go to IDLE, clear ptr, suppress any pending update write and load_done; memory contents are kept; kill overrides all same-cycle requests.

Reset
REQ-030 SHALL on rst low: state IDLE, ptr 0, rd_data 0, rd_valid 0, load_done 0, busy 0, latched addr/delta 0.
REQ-031 SHALL not clear memory contents on reset; reset during UPD_RD/UPD_WR performs no write.

Configuration
REQ-032 SHALL use macro SYN_STDP_SAT_EN: defined -> STDP result is clamped to [0, 2**COL_WIDTH-1]; undefined -> result wraps modulo 2**COL_WIDTH.

Verification
REQ-033 SHALL cover load of 32 words, word i = 0x03020100 + 0x04040404*i -> load_done pulses once after beat 31; read addr 5 returns 0x05 one cycle later.
REQ-034 SHALL cover byte write 0xAA to addr 6 -> read addr 4,5,6,7 return 0x04,0x05,0xAA,0x07.
REQ-035 SHALL cover STDP +0x10 on addr 5 then immediate read -> op_ready low 2 cycles, read returns 0x15.
REQ-036 SHALL cover saturation: write 0xF0, STDP +0x20 -> 0xFF with SYN_STDP_SAT_EN, 0x10 without; write 0x05, STDP 0xF0 (-16) -> 0x00 with, 0xF5 without.
REQ-037 SHALL cover kill after 10 load beats -> no load_done, busy low next cycle; new load rewrites from word 0.
REQ-038 SHALL cover rst asserted in UPD_WR of STDP +1 on addr 3 (0x03) -> outputs zero, later read of addr 3 returns 0x03.
